// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults, request encoding and word-index helper for the memory responder
// Purpose: constants and helpers shared by mem_resp_pipe, its interface and its delay line.
// Ports:   none (package).
package mem_pkg;

    localparam int MEM_ADDR_W  = 16;
    localparam int MEM_DATA_W  = 16;
    localparam int MEM_LATENCY = 4;
    localparam int MEM_DEPTH   = 1024;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_e;

    // Byte address -> word index. Bit 0 is dropped (word-aligned accesses) and
    // everything above the index is masked off, so addresses alias modulo depth.
    // depth is expected to be a power of two.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input int unsigned depth);
        return (addr >> 1) & (depth - 1);
    endfunction

endpackage

// File: rtl/mem_resp_pipe_if.sv
// rtl/mem_resp_pipe_if.sv - request/response bundle between the cache-fill arbiter and the memory responder
// Purpose: groups the request strobe, write data and the read-return signals.
// Ports:   enable/wr/address/data_in (requestor -> memory),
//          memory_data/memory_data_valid/memory_data_addr/outstanding (memory -> requestor).
interface mem_resp_pipe_if #(
    parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W = mem_pkg::MEM_DATA_W
);
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] memory_data;
    logic              memory_data_valid;
    logic [ADDR_W-1:0] memory_data_addr;
    logic [3:0]        outstanding;

    modport master (
        output enable, wr, address, data_in,
        input  memory_data, memory_data_valid, memory_data_addr, outstanding
    );

    modport slave (
        input  enable, wr, address, data_in,
        output memory_data, memory_data_valid, memory_data_addr, outstanding
    );
endinterface

// File: rtl/mem_delay_line.sv
// rtl/mem_delay_line.sv - LATENCY-deep {valid, addr, data} shift register with synchronous clear
// Purpose: carries each read from its issue edge to its return cycle.
// Ports:   clk, i_clr (sync clear of every stage), i_valid/i_addr/i_data (stage 1 input),
//          o_valid/o_addr/o_data (last stage).
module mem_delay_line #(
    parameter int LATENCY = mem_pkg::MEM_LATENCY,
    parameter int ADDR_W  = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W  = mem_pkg::MEM_DATA_W
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data
);
    logic              r_vld  [LATENCY];
    logic [ADDR_W-1:0] r_addr [LATENCY];
    logic [DATA_W-1:0] r_data [LATENCY];

    // Valid bits shift every cycle; payload only moves behind a valid bit, so the
    // last stage keeps its previous addr/data while no read is returning.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_addr[0] <= i_addr;
                r_data[0] <= i_data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_addr[i] <= r_addr[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LATENCY-1];
    assign o_addr  = r_addr[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];
endmodule

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - always-ready main-memory responder with fixed pipelined read latency
// Purpose: word array with one write port and one read port; reads return LATENCY cycles
//          after issue, in order, one per cycle; tracks reads in flight.
// Ports:   clk, rst (sync active-high), bus (mem_resp_pipe_if.slave: request in, read return out).
module mem_resp_pipe #(
    parameter int ADDR_W  = mem_pkg::MEM_ADDR_W,
    parameter int DATA_W  = mem_pkg::MEM_DATA_W,
    parameter int DEPTH   = mem_pkg::MEM_DEPTH,
    parameter int LATENCY = mem_pkg::MEM_LATENCY
) (
    input  logic           clk,
    input  logic           rst,
    mem_resp_pipe_if.slave bus
);
    import mem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [3:0]        r_outstanding;

    req_kind_e         w_kind;
    logic              w_rd_issue;
    logic              w_wr_issue;
    logic [IDX_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_word_addr;
    logic              w_ret_valid;
    logic [ADDR_W-1:0] w_ret_addr;
    logic [DATA_W-1:0] w_ret_data;

    assign w_kind      = req_kind_e'(bus.wr);
    assign w_rd_issue  = bus.enable && (w_kind == REQ_READ);
    assign w_wr_issue  = bus.enable && (w_kind == REQ_WRITE);
    assign w_idx       = IDX_W'(word_index(32'(bus.address), DEPTH));
    assign w_word_addr = {bus.address[ADDR_W-1:1], 1'b0};

    // Storage is not reset; a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_issue) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    // The read samples the array at its issue edge, so a write at the same or a
    // later edge cannot disturb it, while a read one cycle after a write sees it.
    mem_delay_line #(
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) u_delay (
        .clk     (clk),
        .i_clr   (rst),
        .i_valid (w_rd_issue),
        .i_addr  (w_word_addr),
        .i_data  (r_mem[w_idx]),
        .o_valid (w_ret_valid),
        .o_addr  (w_ret_addr),
        .o_data  (w_ret_data)
    );

    // Issue and return in the same cycle cancel; bounded by LATENCY since every
    // issued read leaves the delay line exactly LATENCY cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= 4'd0;
        end else begin
            r_outstanding <= r_outstanding + 4'(w_rd_issue) - 4'(w_ret_valid);
        end
    end

    assign bus.memory_data       = w_ret_data;
    assign bus.memory_data_valid = w_ret_valid;
    assign bus.memory_data_addr  = w_ret_addr;
    assign bus.outstanding       = r_outstanding;
endmodule

// File: tb/tb_mem_resp_pipe.sv
// tb/tb_mem_resp_pipe.sv - self-checking bench for mem_resp_pipe against a queue-based reference model
module tb_mem_resp_pipe;
    localparam int L = 4;
    localparam int D = 1024;

    typedef struct {
        int          e;
        logic [15:0] a;
        logic [15:0] d;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_resp_pipe_if bus ();

    mem_resp_pipe #(.ADDR_W(16), .DATA_W(16), .DEPTH(D), .LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mdl [D];
    rd_t         q [$];
    int          edge_n   = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          peak_out = 0;
    int          n_valid  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic int widx(input logic [15:0] a);
        return (int'(a) / 2) % D;
    endfunction

    // One clock: drive at negedge, update model at posedge, compare 1ns later.
    task automatic cyc(input logic r, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        rd_t t;
        logic exp_v;
        @(negedge clk);
        rst         = r;
        bus.enable  = en;
        bus.wr      = w;
        bus.address = a;
        bus.data_in = d;
        @(posedge clk);
        edge_n++;
        if (r) begin
            q.delete();
        end else if (en && w) begin
            mdl[widx(a)] = d;
        end else if (en) begin
            t.e = edge_n;
            t.a = {a[15:1], 1'b0};
            t.d = mdl[widx(a)];
            q.push_back(t);
        end
        #1;
        exp_v = (q.size() > 0) && (q[0].e + L - 1 == edge_n);
        check("outstanding", 32'(bus.outstanding), 32'(q.size()));
        check("valid", 32'(bus.memory_data_valid), 32'(exp_v));
        if (int'(bus.outstanding) > peak_out) peak_out = int'(bus.outstanding);
        if (bus.memory_data_valid) n_valid++;
        if (exp_v) begin
            check("data", 32'(bus.memory_data), 32'(q[0].d));
            check("addr", 32'(bus.memory_data_addr), 32'(q[0].a));
            q.delete(0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.address = '0;
        bus.data_in = '0;

        cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        check("rst_data", 32'(bus.memory_data), 32'h0);
        check("rst_addr", 32'(bus.memory_data_addr), 32'h0);

        // Fill every word so any later read has a defined expectation.
        for (int i = 0; i < D; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'($urandom));

        // Single write then read with exact latency.
        cyc(1'b0, 1'b1, 1'b1, 16'hABCC, 16'hCDEF);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 16'hABCC, 16'h0);
        idle(6);

        // Streaming reads, one per cycle.
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i * 2), 16'(16'h1000 + i));
        peak_out = 0;
        n_valid  = 0;
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 16'(i * 2), 16'h0);
        idle(6);
        check("stream_peak", 32'(peak_out), 32'(L));
        check("stream_count", 32'(n_valid), 32'd8);

        // Read/write/read hazard on one word.
        cyc(1'b0, 1'b1, 1'b1, 16'h0010, 16'h1111);
        n_valid = 0;
        cyc(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        cyc(1'b0, 1'b1, 1'b1, 16'h0010, 16'h2222);
        cyc(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        idle(6);
        check("hazard_count", 32'(n_valid), 32'd2);

        // Reset drops in-flight reads.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'h0);
        n_valid = 0;
        cyc(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0);
        idle(8);
        check("rst_drop_count", 32'(n_valid), 32'd0);

        // Alternating read/idle, then an odd address that aliases.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'(16'h0300 + 2 * i), 16'h0);
            idle(1);
        end
        cyc(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0);
        idle(6);

        // Write during reset is ignored.
        cyc(1'b0, 1'b1, 1'b1, 16'h0040, 16'h5A5A);
        cyc(1'b1, 1'b1, 1'b1, 16'h0040, 16'hDEAD);
        cyc(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0);
        idle(5);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int unsigned op;
            op = $urandom_range(0, 99);
            cyc((op == 0), (op >= 30), (op >= 75), 16'($urandom), 16'($urandom));
        end
        idle(L + 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
